// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: ALU operations,
// controller states, opcodes and immediate-type selects.
package DataTypes_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_SrB  = 4'd10
    } ALUop_t;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format depends only on the opcode, never on the state.
    function automatic logic [2:0] immSrcOf(input logic [6:0] op);
        case (op)
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_JAL:            return IMM_J;
            OP_LUI, OP_AUIPC:  return IMM_U;
            default:           return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle datapath (master) and the
// controller (slave): instruction fields and status in, enables and selects out.
interface multicycle_ctrl_if;
    import DataTypes_pkg::*;

    logic [6:0] Op;
    logic [2:0] Funct3;
    logic       Funct7b5;
    logic       Zero;
    logic       MemReady;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    ALUop_t     ALUControl;
    logic       Illegal;

    modport master (
        output Op, Funct3, Funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal
    );

    modport slave (
        input  Op, Funct3, Funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal
    );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps Funct3/Funct7b5 to an ALU operation for register and immediate
// arithmetic. Immediate forms never subtract, since bit 30 is immediate data there.
module alu_decoder
    import DataTypes_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_isRType,
    output ALUop_t     o_aluOp
);

    // Pure lookup on funct3, with bit 30 selecting SUB / SRA where it applies.
    always_comb begin
        o_aluOp = ALU_ADD;
        case (i_funct3)
            3'b000:  o_aluOp = (i_isRType && i_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  o_aluOp = ALU_SLL;
            3'b010:  o_aluOp = ALU_SLT;
            3'b011:  o_aluOp = ALU_SLTU;
            3'b100:  o_aluOp = ALU_XOR;
            3'b101:  o_aluOp = i_funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  o_aluOp = ALU_OR;
            default: o_aluOp = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V main controller: a registered state FSM whose outputs
// are decoded combinationally from the current state and instruction fields.
module multicycle_ctrl
    import DataTypes_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    multicycle_ctrl_if.slave  bus
);

    state_t     r_state;
    logic       w_isRType;
    ALUop_t     w_aluDecOp;
    logic       w_pcWrite;
    logic       w_memWrite;
    logic       w_irWrite;
    logic       w_regWrite;
    logic       w_branchTaken;

    assign w_isRType = (r_state == EXECUTER);

    alu_decoder u_aluDecoder (
        .i_funct3   (bus.Funct3),
        .i_funct7b5 (bus.Funct7b5),
        .i_isRType  (w_isRType),
        .o_aluOp    (w_aluDecOp)
    );

    // State sequencing; memory states wait on MemReady, ILLEGAL only leaves via reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH:    if (bus.MemReady) r_state <= DECODE;
                DECODE: begin
                    case (bus.Op)
                        OP_LOAD, OP_STORE: r_state <= MEMADR;
                        OP_RTYPE:          r_state <= EXECUTER;
                        OP_ITYPE:          r_state <= EXECUTEI;
                        OP_BRANCH:         r_state <= BRANCH;
                        OP_JAL:            r_state <= JAL;
                        OP_JALR:           r_state <= JALR;
                        OP_LUI:            r_state <= LUI;
                        OP_AUIPC:          r_state <= AUIPC;
                        default:           r_state <= ILLEGAL;
                    endcase
                end
                MEMADR:   r_state <= (bus.Op == OP_LOAD) ? MEMREAD : MEMWRITE;
                MEMREAD:  if (bus.MemReady) r_state <= MEMWB;
                MEMWB:    r_state <= FETCH;
                MEMWRITE: if (bus.MemReady) r_state <= FETCH;
                EXECUTER: r_state <= ALUWB;
                EXECUTEI: r_state <= ALUWB;
                ALUWB:    r_state <= FETCH;
                BRANCH:   r_state <= FETCH;
                JALR:     r_state <= JAL;
                JAL:      r_state <= ALUWB;
                LUI:      r_state <= ALUWB;
                AUIPC:    r_state <= ALUWB;
                default:  r_state <= ILLEGAL;
            endcase
        end
    end

    // Branch condition: beq/bge/bgeu take on Zero, bne/blt/bltu on !Zero.
    always_comb begin
        w_branchTaken = 1'b0;
        case (bus.Funct3)
            3'b000, 3'b101, 3'b111: w_branchTaken = bus.Zero;
            3'b001, 3'b100, 3'b110: w_branchTaken = !bus.Zero;
            default:                w_branchTaken = 1'b0;
        endcase
    end

    // Per-state datapath controls; write enables are gated by reset afterwards.
    always_comb begin
        w_pcWrite      = 1'b0;
        w_memWrite     = 1'b0;
        w_irWrite      = 1'b0;
        w_regWrite     = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ResultSrc  = 2'b00;
        bus.ALUSrcA    = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = ALU_ADD;
        bus.Illegal    = 1'b0;
        case (r_state)
            FETCH: begin
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                w_irWrite     = bus.MemReady;
                w_pcWrite     = bus.MemReady;
            end
            DECODE: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            MEMADR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            MEMREAD: bus.AdrSrc = 1'b1;
            MEMWB: begin
                bus.ResultSrc = 2'b01;
                w_regWrite    = 1'b1;
            end
            MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                w_memWrite = 1'b1;
            end
            EXECUTER: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUControl = w_aluDecOp;
            end
            EXECUTEI: begin
                bus.ALUSrcA    = 2'b10;
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = w_aluDecOp;
            end
            ALUWB: w_regWrite = 1'b1;
            BRANCH: begin
                bus.ALUSrcA = 2'b10;
                case (bus.Funct3[2:1])
                    2'b00:   bus.ALUControl = ALU_SUB;
                    2'b10:   bus.ALUControl = ALU_SLT;
                    2'b11:   bus.ALUControl = ALU_SLTU;
                    default: bus.ALUControl = ALU_ADD;
                endcase
                w_pcWrite = w_branchTaken;
            end
            JALR: begin
                bus.ALUSrcA = 2'b10;
                bus.ALUSrcB = 2'b01;
            end
            JAL: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b10;
                w_pcWrite   = 1'b1;
            end
            LUI: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = ALU_SrB;
            end
            AUIPC: begin
                bus.ALUSrcA = 2'b01;
                bus.ALUSrcB = 2'b01;
            end
            default: bus.Illegal = 1'b1;
        endcase
    end

    assign bus.ImmSrc   = immSrcOf(bus.Op);
    assign bus.PCWrite  = w_pcWrite  && !reset;
    assign bus.MemWrite = w_memWrite && !reset;
    assign bus.IRWrite  = w_irWrite  && !reset;
    assign bus.RegWrite = w_regWrite && !reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares the whole control word against hand-written values.
module tb_multicycle_ctrl;
    import DataTypes_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [2:0] im;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,Illegal}
    function automatic logic [18:0] sig(input logic pcw, adr, mw, irw, rw,
                                        input logic [1:0] rs, sa, sb,
                                        input logic [2:0] imm, input ALUop_t alu,
                                        input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
    endfunction

    function automatic logic [18:0] observed();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl,
                bus.Illegal};
    endfunction

    task automatic checkOutput(input string tag, input logic [18:0] actual,
                               input logic [18:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic f7, input logic [2:0] immExp);
        bus.Op       = op;
        bus.Funct3   = f3;
        bus.Funct7b5 = f7;
        im           = immExp;
    endtask

    // One clock cycle: drive, sample at the falling edge, advance past the rising edge.
    task automatic cyc(input string tag, input logic rst, input logic mr,
                       input logic z, input logic [18:0] expected);
        reset        = rst;
        bus.MemReady = mr;
        bus.Zero     = z;
        @(negedge clk);
        checkOutput(tag, observed(), expected);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] eFetch(input logic mr);
        return sig(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, im, ALU_ADD, 0);
    endfunction
    function automatic logic [18:0] eDecode();
        return sig(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, ALU_ADD, 0);
    endfunction
    function automatic logic [18:0] eExecR(input ALUop_t a);
        return sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, a, 0);
    endfunction
    function automatic logic [18:0] eExecI(input ALUop_t a);
        return sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, a, 0);
    endfunction
    function automatic logic [18:0] eAluWb();
        return sig(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, ALU_ADD, 0);
    endfunction
    function automatic logic [18:0] eBranch(input ALUop_t a, input logic pcw);
        return sig(pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, im, a, 0);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(7'b0110011, 3'b000, 1'b0, 3'b000);
        bus.MemReady = 1'b1;
        bus.Zero     = 1'b0;

        // Reset: FETCH controls, write enables suppressed
        cyc("rst_fetch", 1, 1, 0, sig(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, ALU_ADD, 0));
        cyc("fetch_wait", 0, 0, 0, eFetch(0));

        // add x3,x1,x2
        cyc("add_fetch", 0, 1, 0, eFetch(1));
        cyc("add_decode", 0, 1, 0, eDecode());
        cyc("add_exec", 0, 1, 0, eExecR(ALU_ADD));
        cyc("add_wb", 0, 1, 0, eAluWb());

        // sub x3,x1,x2
        applyStimulus(7'b0110011, 3'b000, 1'b1, 3'b000);
        cyc("sub_fetch", 0, 1, 0, eFetch(1));
        cyc("sub_decode", 0, 1, 0, eDecode());
        cyc("sub_exec", 0, 1, 0, eExecR(ALU_SUB));
        cyc("sub_wb", 0, 1, 0, eAluWb());

        // srai x3,x1,2
        applyStimulus(7'b0010011, 3'b101, 1'b1, 3'b000);
        cyc("srai_fetch", 0, 1, 0, eFetch(1));
        cyc("srai_decode", 0, 1, 0, eDecode());
        cyc("srai_exec", 0, 1, 0, eExecI(ALU_SRA));
        cyc("srai_wb", 0, 1, 0, eAluWb());

        // addi with bit30 set still adds
        applyStimulus(7'b0010011, 3'b000, 1'b1, 3'b000);
        cyc("addi_fetch", 0, 1, 0, eFetch(1));
        cyc("addi_decode", 0, 1, 0, eDecode());
        cyc("addi_exec", 0, 1, 0, eExecI(ALU_ADD));
        cyc("addi_wb", 0, 1, 0, eAluWb());

        // beq taken / not taken, bltu-style 110, and non-branch 010
        applyStimulus(7'b1100011, 3'b000, 1'b0, 3'b010);
        cyc("beq_fetch", 0, 1, 0, eFetch(1));
        cyc("beq_decode", 0, 1, 0, eDecode());
        cyc("beq_taken", 0, 1, 1, eBranch(ALU_SUB, 1));
        cyc("beq2_fetch", 0, 1, 0, eFetch(1));
        cyc("beq2_decode", 0, 1, 0, eDecode());
        cyc("beq_nottaken", 0, 1, 0, eBranch(ALU_SUB, 0));
        applyStimulus(7'b1100011, 3'b110, 1'b0, 3'b010);
        cyc("bltu_fetch", 0, 1, 0, eFetch(1));
        cyc("bltu_decode", 0, 1, 0, eDecode());
        cyc("bltu_taken", 0, 1, 0, eBranch(ALU_SLTU, 1));
        applyStimulus(7'b1100011, 3'b010, 1'b0, 3'b010);
        cyc("b010_fetch", 0, 1, 0, eFetch(1));
        cyc("b010_decode", 0, 1, 0, eDecode());
        cyc("b010_never", 0, 1, 1, eBranch(ALU_ADD, 0));

        // lw with three wait cycles in MEMREAD
        applyStimulus(7'b0000011, 3'b010, 1'b0, 3'b000);
        cyc("lw_fetch", 0, 1, 0, eFetch(1));
        cyc("lw_decode", 0, 1, 0, eDecode());
        cyc("lw_memadr", 0, 1, 0, sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, ALU_ADD, 0));
        for (int i = 0; i < 3; i++)
            cyc("lw_memread_wait", 0, 0, 0, sig(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, ALU_ADD, 0));
        cyc("lw_memread_done", 0, 1, 0, sig(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, ALU_ADD, 0));
        cyc("lw_memwb", 0, 1, 0, sig(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, ALU_ADD, 0));

        // sw with reset landing in the second MEMWRITE cycle
        applyStimulus(7'b0100011, 3'b010, 1'b0, 3'b001);
        cyc("sw_fetch", 0, 1, 0, eFetch(1));
        cyc("sw_decode", 0, 1, 0, eDecode());
        cyc("sw_memadr", 0, 1, 0, sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, ALU_ADD, 0));
        cyc("sw_memwrite", 0, 0, 0, sig(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, im, ALU_ADD, 0));
        cyc("sw_memwrite_rst", 1, 0, 0, sig(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, ALU_ADD, 0));
        cyc("sw_after_rst", 0, 1, 0, eFetch(1));

        // jal
        applyStimulus(7'b1101111, 3'b000, 1'b0, 3'b011);
        cyc("jal_decode", 0, 1, 0, eDecode());
        cyc("jal_jal", 0, 1, 0, sig(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, ALU_ADD, 0));
        cyc("jal_wb", 0, 1, 0, eAluWb());

        // jalr
        applyStimulus(7'b1100111, 3'b000, 1'b0, 3'b000);
        cyc("jalr_fetch", 0, 1, 0, eFetch(1));
        cyc("jalr_decode", 0, 1, 0, eDecode());
        cyc("jalr_jalr", 0, 1, 0, sig(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, ALU_ADD, 0));
        cyc("jalr_jal", 0, 1, 0, sig(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, im, ALU_ADD, 0));
        cyc("jalr_wb", 0, 1, 0, eAluWb());

        // lui and auipc
        applyStimulus(7'b0110111, 3'b000, 1'b0, 3'b100);
        cyc("lui_fetch", 0, 1, 0, eFetch(1));
        cyc("lui_decode", 0, 1, 0, eDecode());
        cyc("lui_lui", 0, 1, 0, sig(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, im, ALU_SrB, 0));
        cyc("lui_wb", 0, 1, 0, eAluWb());
        applyStimulus(7'b0010111, 3'b000, 1'b0, 3'b100);
        cyc("auipc_fetch", 0, 1, 0, eFetch(1));
        cyc("auipc_decode", 0, 1, 0, eDecode());
        cyc("auipc_auipc", 0, 1, 0, sig(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, ALU_ADD, 0));
        cyc("auipc_wb", 0, 1, 0, eAluWb());

        // all-zero instruction traps and stays trapped until reset
        applyStimulus(7'b0000000, 3'b000, 1'b0, 3'b000);
        cyc("ill_fetch", 0, 1, 0, eFetch(1));
        cyc("ill_decode", 0, 1, 0, eDecode());
        for (int i = 0; i < 10; i++)
            cyc("ill_hold", 0, 1, 1, sig(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, ALU_ADD, 1));
        cyc("ill_rst", 1, 1, 0, sig(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, ALU_ADD, 1));
        cyc("ill_recover", 0, 1, 0, eFetch(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
